dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-through data-cache controller for the 16-bit pipeline. Responds to MEM-stage load/store requests, serves read hits with zero stall, and fetches misses or forwards stores to main memory over a request/ready handshake. It produces the `hit` signal that the pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) use as their advance enable on the falling edge. `hit=0` freezes the whole pipeline.

## Interface

Parameters:
- LINES, 8, number of one-word cache lines; index width is log2(LINES) = 3.
- AW, 16, address width in words.
- DW, 16, data width.

Ports:
- clk  in  1  clock; controller state updates on posedge; pipeline registers sample `hit` on negedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  load request from the MEM stage.
- cpu_wr  in  1  store request from the MEM stage. Has priority if asserted together with cpu_rd.
- cpu_addr  in  16  word address; index = [2:0], tag = [15:3] (13 bits).
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid whenever hit=1 and cpu_rd=1.
- hit  out  1  pipeline advance enable.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1.
- mem_addr  out  16  registered request address.
- mem_wdata  out  16  registered store data.
- mem_rdata  in  16  memory read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse; ignored when mem_req=0.

## Operation

- Storage per line: valid bit, 13-bit tag, 16-bit data.
- Reset clears only the valid bits; tag and data arrays are not reset.
- States: IDLE, RD_MISS, WR_THRU, WR_DONE.
- IDLE:
  - No request: hit=1.
  - cpu_rd with valid and tag match: hit=1, cpu_rdata = line data; state stays IDLE.
  - cpu_rd miss (and no cpu_wr): hit=0; latch address; next state RD_MISS.
  - cpu_wr: hit=0; latch address and data; next state WR_THRU.
- RD_MISS:
  - mem_req=1, mem_we=0, hit=0.
  - On mem_ready: write mem_rdata into the line, set its tag and valid bit; next state IDLE.
  - The retried read then hits in IDLE.
- WR_THRU:
  - mem_req=1, mem_we=1, hit=0.
  - On mem_ready: if the line is valid with a matching tag, update its data to the latched store data (write-through update). Otherwise leave the line untouched (no write-allocate).
  - Next state WR_DONE.
- WR_DONE:
  - hit=1 for exactly one cycle, so the store retires on that negedge; next state IDLE.
  - cpu_rd/cpu_wr are not re-evaluated in this state.
- cpu_rdata in non-IDLE states: drives the indexed line data but is don't-care.
- mem_addr/mem_wdata hold their latched values after the transaction completes.

## Timing

- Reset values (async, immediate):
  - State IDLE, all valid bits 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - hit follows IDLE decode (1 with no request).
  - An in-flight memory transaction is abandoned.
- hit and cpu_rdata are combinational from state, request, and arrays. mem_req and mem_we are decoded from state only.
- Read hit: 0 stall cycles.
- Read miss, with memory latency L = posedges from mem_req rising to mem_ready high:
  - Edge 0: IDLE→RD_MISS.
  - Edge L: mem_ready sampled; fill.
  - Next cycle: IDLE hit.
  - Total stall is L+1 cycles.
- Store: stall is L+1 cycles, then one WR_DONE cycle with hit=1.
- A mem_ready arriving in the same edge as the state entry is not possible; mem_req rises after edge 0, so L ≥ 1.
- A mem_ready pulse in IDLE or WR_DONE is ignored.
- Back-to-back misses to the same index: the second miss evicts the first line.

## Test plan

- Reset, then cpu_rd to addr 0x0008 -> hit=0, mem_req=1, mem_we=0, mem_addr=0x0008. mem_ready with mem_rdata=0xBEEF after 3 cycles -> next cycle hit=1, cpu_rdata=0xBEEF.
- Repeat read of 0x0008 -> hit=1 in the same cycle, no mem_req. Read 0x0010 (same index 0, tag 2) -> miss. Fill 0x1234. Read 0x0008 again -> miss (evicted).
- cpu_wr 0x0008 data 0x5555 while the line is valid -> mem_req=1, mem_we=1, mem_wdata=0x5555. After mem_ready, hit=1 for exactly one cycle. Following read of 0x0008 -> hit, 0x5555.
- cpu_wr to uncached 0x0021 data 0x00AA -> write forwarded. Subsequent read of 0x0021 -> miss (no allocate).
- cpu_rd and cpu_wr asserted together -> write path taken (mem_we=1).
- rst_n low during RD_MISS -> mem_req=0 immediately. After release, a read of a previously filled address misses. A stray mem_ready in IDLE -> no state change.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// hit doubles as the pipeline advance enable; memory side uses req/ready.
module dcache_ctrl #(
  parameter int LINES = 8,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          hit,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [1:0]    dbgState
);

  localparam int IW = $clog2(LINES);
  localparam int TW = AW - IW;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, WR_DONE} state_t;

  // Handshake: mem_req rises after the posedge that enters RD_MISS/WR_THRU and
  // stays high, with mem_addr/mem_we/mem_wdata stable, until the posedge that
  // samples mem_ready=1. mem_ready is ignored whenever mem_req is low.
  state_t            state;
  logic [LINES-1:0]  validArr;
  logic [TW-1:0]     tagArr [LINES];
  logic [DW-1:0]     dataArr[LINES];

  logic [IW-1:0] cpuIdx;
  logic [TW-1:0] cpuTag;
  logic [IW-1:0] memIdx;
  logic [TW-1:0] memTag;
  logic          lineHit;
  logic          fill;
  logic          wrUpdate;

  assign cpuIdx   = cpu_addr[IW-1:0];
  assign cpuTag   = cpu_addr[AW-1:IW];
  assign memIdx   = mem_addr[IW-1:0];
  assign memTag   = mem_addr[AW-1:IW];
  assign lineHit  = validArr[cpuIdx] && (tagArr[cpuIdx] == cpuTag);
  assign fill     = (state == RD_MISS) && mem_ready;
  assign wrUpdate = (state == WR_THRU) && mem_ready &&
                    validArr[memIdx] && (tagArr[memIdx] == memTag);

  assign cpu_rdata = dataArr[cpuIdx];
  assign dbgState  = state;

  always_comb begin
    hit = 1'b0;
    case (state)
      IDLE:    hit = !(cpu_wr || (cpu_rd && !lineHit));
      WR_DONE: hit = 1'b1;
      default: hit = 1'b0;
    endcase
  end

  // Tag and data arrays carry no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (fill) begin
      tagArr[memIdx]  <= memTag;
      dataArr[memIdx] <= mem_rdata;
    end else if (wrUpdate) begin
      dataArr[memIdx] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      validArr  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= WR_THRU;
          end else if (cpu_rd && !lineHit) begin
            mem_addr <= cpu_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state    <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            validArr[memIdx] <= 1'b1;
            mem_req          <= 1'b0;
            state            <= IDLE;
          end
        end
        WR_THRU: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WR_DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed cases plus random loads/stores against a
// line-level cache model and an associative-array main memory.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        hit, mem_req, mem_we, mem_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbgState;

  int checks = 0;
  int errors = 0;

  // Model: each line remembers the full word address it holds.
  bit          m_valid [8];
  logic [15:0] m_addr  [8];
  logic [15:0] m_data  [8];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_q [$];

  dcache_ctrl #(.LINES(8), .AW(16), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .hit(hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .dbgState(dbgState)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_get(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return m_valid[a % 8] && (m_addr[a % 8] == a);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input int lat);
    bit exp_hit;
    int idx;
    idx = addr % 8;
    exp_hit = model_hit(addr);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
    #1;
    check_val("rd_first_hit", hit, exp_hit);
    if (exp_hit) begin
      check_val("rd_hit_no_req", mem_req, 0);
    end else begin
      @(posedge clk); #1;
      check_val("rd_miss_req", mem_req, 1);
      check_val("rd_miss_we", mem_we, 0);
      check_val("rd_miss_addr", mem_addr, addr);
      check_val("rd_miss_stall", hit, 0);
      repeat (lat - 1) @(posedge clk);
      @(negedge clk);
      mem_ready = 1'b1; mem_rdata = mem_get(addr);
      #1;
      check_val("rd_wait_stall", hit, 0);
      @(posedge clk); #1;
      m_valid[idx] = 1'b1; m_addr[idx] = addr; m_data[idx] = mem[addr];
      @(negedge clk);
      mem_ready = 1'b0; mem_rdata = 16'h0;
      #1;
      check_val("rd_retry_hit", hit, 1);
      check_val("rd_retry_no_req", mem_req, 0);
    end
    exp_q.push_back(m_data[idx]);
    check_val("rd_data", cpu_rdata, exp_q.pop_front());
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data,
                          input int lat, input bit both);
    @(negedge clk);
    cpu_wr = 1'b1; cpu_rd = both; cpu_addr = addr; cpu_wdata = data;
    #1;
    check_val("wr_first_stall", hit, 0);
    @(posedge clk); #1;
    check_val("wr_req", mem_req, 1);
    check_val("wr_we", mem_we, 1);
    check_val("wr_addr", mem_addr, addr);
    check_val("wr_wdata", mem_wdata, data);
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("wr_wait_stall", hit, 0);
    @(posedge clk); #1;
    mem[addr] = data;
    if (model_hit(addr)) m_data[addr % 8] = data;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check_val("wr_done_hit", hit, 1);
    check_val("wr_done_no_req", mem_req, 0);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;
    check_val("wr_back_idle", dbgState, 0);
    check_val("wr_idle_hit", hit, 1);
    check_val("wr_hold_addr", mem_addr, addr);
  endtask

  initial begin
    rst_n = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0;
    cpu_wdata = 16'h0; mem_ready = 1'b0; mem_rdata = 16'h0;
    model_clear();
    mem[16'h0008] = 16'hBEEF;
    mem[16'h0010] = 16'h1234;
    #12;
    check_val("rst_hit", hit, 1);
    check_val("rst_req", mem_req, 0);
    check_val("rst_we", mem_we, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_wdata, 0);
    check_val("rst_state", dbgState, 0);
    @(negedge clk); rst_n = 1'b1;

    do_read(16'h0008, 3);           // cold miss, fill BEEF
    do_read(16'h0008, 1);           // hit
    do_read(16'h0010, 2);           // same index, evicts
    do_read(16'h0008, 1);           // miss again
    do_write(16'h0008, 16'h5555, 2, 1'b0);
    do_read(16'h0008, 1);           // hit with updated data
    do_write(16'h0021, 16'h00AA, 1, 1'b0);
    do_read(16'h0021, 2);           // no allocate -> miss
    do_write(16'h0008, 16'h7777, 3, 1'b1);  // rd+wr together
    do_read(16'h0008, 1);

    // Reset in the middle of a read miss
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 16'h0030;
    @(posedge clk); #1;
    check_val("pre_rst_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", mem_req, 0);
    check_val("mid_rst_addr", mem_addr, 0);
    check_val("mid_rst_state", dbgState, 0);
    check_val("mid_rst_rd_miss", hit, 0);
    cpu_rd = 1'b0;
    #1;
    check_val("mid_rst_idle_hit", hit, 1);
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    do_read(16'h0008, 2);           // valid bits gone -> miss

    // Stray ready in IDLE
    @(negedge clk); mem_ready = 1'b1; mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    check_val("stray_state", dbgState, 0);
    check_val("stray_req", mem_req, 0);
    @(negedge clk); mem_ready = 1'b0;
    do_read(16'h0008, 1);           // line must not have been touched

    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      a = 16'(($urandom_range(0, 3) * 8) + $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6)
        do_read(a, $urandom_range(1, 4));
      else
        do_write(a, 16'($urandom), $urandom_range(1, 4), $urandom_range(0, 3) == 0);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
